// File: rtl/lcd_host.sv
// LCD host: image buffer with ROM responder, command FIFO, frame sequencer and result capture.
// Optional watchdog is built only when LCD_HOST_TIMEOUT_EN is defined.
module lcd_host #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        img_we,
  input  logic [5:0]  img_addr,
  input  logic [7:0]  img_data,
  input  logic [3:0]  cmd_in,
  input  logic        cmd_in_valid,
  output logic        cmd_in_ready,
  output logic [3:0]  cmd,
  output logic        cmd_valid,
  input  logic        busy,
  input  logic        done,
  input  logic        IROM_rd,
  input  logic [5:0]  IROM_A,
  output logic [7:0]  IROM_Q,
  input  logic        IRAM_valid,
  input  logic [5:0]  IRAM_A,
  input  logic [7:0]  IRAM_D,
  input  logic [5:0]  res_addr,
  output logic [7:0]  res_data,
  output logic        frame_done,
  output logic [13:0] checksum,
  output logic [6:0]  wr_count,
  output logic        err,
  output logic        bad_cmd,
  output logic        timeout
);

  localparam int AW = $clog2(FIFO_DEPTH);

  generate
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("lcd_host: FIFO_DEPTH must be a power of two, at least 2");
    end
    if (TIMEOUT < 2) begin : g_bad_timeout
      $error("lcd_host: TIMEOUT must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {LOAD, ISSUE, DRAIN, REPORT} state_t;

  state_t state, state_next;

  logic [7:0] image  [64];
  logic [7:0] result [64];

  logic [3:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty, push, pop;
  logic [3:0]    head;

  logic          capture, beat, tmo_hit;
  logic [13:0]   acc, acc_next;
  logic [6:0]    cnt, cnt_next;

  // Buffers keep their contents across reset; reset only blocks writes while asserted.
  always_ff @(posedge clk) begin
    if (reset && img_we) image[img_addr] <= img_data;
  end

  always_ff @(posedge clk) begin
    if (reset && IRAM_valid) result[IRAM_A] <= IRAM_D;
  end

  assign IROM_Q   = IROM_rd ? image[IROM_A] : 8'h00;
  assign res_data = result[res_addr];

  assign fifo_full    = (fifo_count == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty   = (fifo_count == '0);
  assign cmd_in_ready = reset && !fifo_full;
  assign push         = cmd_in_valid && cmd_in_ready && (cmd_in <= 4'd11);
  assign pop          = cmd_valid;
  assign head         = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  // Full blocks a push even when the same cycle pops, so count never needs a bypass.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (!busy) state_next = ISSUE;
      ISSUE:   if (cmd_valid && head == 4'd0) state_next = DRAIN;
      DRAIN:   if (done) state_next = REPORT;
      REPORT:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
    if (tmo_hit) state_next = LOAD;
  end

  // The LCD decodes cmd==0 even without cmd_valid, so idle cmd is parked at 4'hF.
  always_comb begin
    cmd_valid = 1'b0;
    cmd       = 4'hF;
    capture   = (state == DRAIN) || (state == REPORT);
    if (reset && state == ISSUE && !busy && !fifo_empty) begin
      cmd_valid = 1'b1;
      cmd       = head;
    end
  end

  assign beat = IRAM_valid && capture;

  always_comb begin
    acc_next = acc;
    cnt_next = cnt;
    if (beat) begin
      acc_next = acc + 14'(IRAM_D);
      if (cnt != 7'd127) cnt_next = cnt + 7'd1;
    end
  end

  // REPORT folds in a beat arriving with done before latching the frame statistics.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc        <= '0;
      cnt        <= '0;
      checksum   <= '0;
      wr_count   <= '0;
      frame_done <= 1'b0;
      err        <= 1'b0;
      bad_cmd    <= 1'b0;
    end else begin
      frame_done <= (state == REPORT);
      bad_cmd    <= cmd_in_valid && (cmd_in > 4'd11);
      if (state == REPORT) begin
        checksum <= acc_next;
        wr_count <= cnt_next;
        acc      <= '0;
        cnt      <= '0;
        if (cnt_next != 7'd64) err <= 1'b1;
      end else if (tmo_hit) begin
        acc <= '0;
        cnt <= '0;
      end else if (state == DRAIN) begin
        acc <= acc_next;
        cnt <= cnt_next;
      end
      if (IRAM_valid && !capture) err <= 1'b1;
      if (done && state != DRAIN) err <= 1'b1;
    end
  end

`ifdef LCD_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_cnt;
  logic          timeout_q;

  assign tmo_hit = ((state == LOAD) || (state == DRAIN)) && (tmo_cnt == TW'(TIMEOUT - 1));
  assign timeout = timeout_q;

  // Watchdog only ages the states that wait on the LCD; any state change restarts it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (tmo_hit || state_next != state) tmo_cnt <= '0;
      else if (state == LOAD || state == DRAIN) tmo_cnt <= tmo_cnt + TW'(1);
      if (tmo_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: doc/lcd_host.md
LCD_HOST -- requirements
Module: lcd_host

Interface
REQ-001 Parameter FIFO_DEPTH, 8: command FIFO depth; power of two, minimum 2.
REQ-002 Parameter TIMEOUT, 256: watchdog limit in cycles, used only when LCD_HOST_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset; samples on the rising clk edge and overrides all other inputs.
REQ-005 img_we / img_addr / img_data  in  1/6/8  host write port into the 64x8 image buffer.
REQ-006 cmd_in / cmd_in_valid / cmd_in_ready  in/in/out  4/1/1  upstream command push (valid/ready).
REQ-007 cmd / cmd_valid  out  4/1  command output to the LCD controller.
REQ-008 busy / done  in  1/1  status inputs from the LCD controller.
REQ-009 IROM_rd / IROM_A / IROM_Q  in/in/out  1/6/8  image ROM responder port.
REQ-010 IRAM_valid / IRAM_A / IRAM_D  in/in/in  1/6/8  result RAM capture port.
REQ-011 res_addr / res_data  in/out  6/8  combinational readback of the result buffer.
REQ-012 frame_done / checksum / wr_count  out  1/14/7  frame-complete pulse with its statistics.
REQ-013 err / bad_cmd / timeout  out  1/1/1  sticky protocol error, invalid-code pulse, and sticky watchdog flag.

Function
REQ-014 IROM_Q = image[IROM_A], combinational, whenever IROM_rd=1; 0 otherwise.
REQ-015 img_we writes image[img_addr] on the clock edge; the buffer is never written from the LCD side.
REQ-016 Command FIFO: cmd_in_ready = !full; a push when full is blocked, even in a cycle that also pops; cmd_in > 11 is dropped and bad_cmd pulses for 1 cycle.
REQ-017 FSM states: LOAD, ISSUE, DRAIN, REPORT. Reset state is LOAD.
REQ-018 LOAD: cmd_valid=0; when busy=0 is sampled, the FSM goes to ISSUE.
REQ-019 ISSUE: when busy=0 and the FIFO is non-empty, pop 1 entry per cycle and drive cmd/cmd_valid=1 in that same cycle.
REQ-020 ISSUE with code 0 (write): pop it, drive it for exactly 1 cycle, then go to DRAIN; no further pops until REPORT completes.
REQ-021 When cmd_valid=0, cmd SHALL be 4'hF, because the LCD decodes cmd==0 regardless of cmd_valid.
REQ-022 DRAIN: each IRAM_valid=1 cycle writes result[IRAM_A]=IRAM_D, adds IRAM_D to a 14-bit accumulator, and increments a 7-bit counter (saturating at 127).
REQ-023 DRAIN: done=1 moves the FSM to REPORT. An IRAM_valid beat in that same cycle is captured before the values are reported.
REQ-024 REPORT (1 cycle): frame_done=1, and checksum/wr_count are registered from the accumulators.
REQ-025 REPORT: err sets if wr_count != 64; the accumulators clear; the FSM returns to LOAD.
REQ-026 checksum and wr_count hold their values until the next REPORT.
REQ-027 IRAM_valid outside DRAIN/REPORT: the data is still written to the result buffer, but err sets and the accumulators are unchanged.
REQ-028 done outside DRAIN sets err and does not change the FSM state.
REQ-029 busy=1 in ISSUE with a non-empty FIFO: hold, and do not pop.

Reset
REQ-030 On reset=0: FSM=LOAD, FIFO empty, cmd=4'hF, cmd_valid=0, cmd_in_ready=0.
REQ-031 On reset=0: frame_done=0, checksum=0, wr_count=0, err=0, bad_cmd=0, timeout=0, accumulators=0.
REQ-032 Image and result buffers are not reset; their contents are preserved across reset.
REQ-033 Reset mid-DRAIN abandons the frame: no frame_done, and partial counts are discarded.

Configuration
REQ-034 Macro LCD_HOST_TIMEOUT_EN defined: a cycle counter runs in LOAD and DRAIN and clears on each FSM transition.
REQ-035 With LCD_HOST_TIMEOUT_EN, the counter reaching TIMEOUT sets timeout (sticky) and forces the FSM to LOAD.
REQ-036 Macro LCD_HOST_TIMEOUT_EN undefined: no counter is built and timeout is tied to 0.

Verification
REQ-037 Load image[i]=i, push {0}, LCD model reads 64 then writes back unchanged -> frame_done once, checksum=2016, wr_count=64, err=0.
REQ-038 Push {5,0} at default operation point with image[i]=i -> writes: result[27,28,35,36]=36 and others unchanged.
REQ-038a Same scenario -> checksum = 2016 - (27+28+35) + 3*36 = 2034.
REQ-039 Push 9 commands with FIFO_DEPTH=8 while busy=1 -> cmd_in_ready=0 after the 8th push and the 9th is held; push 4'd12 -> bad_cmd pulse and FIFO count unchanged.
REQ-040 Idle with an empty FIFO for 100 cycles -> cmd=4'hF and cmd_valid=0 throughout, and no spurious LCD write.
REQ-041 LCD model emits only 63 IRAM beats then done -> wr_count=63 and err=1.
REQ-041a With LCD_HOST_TIMEOUT_EN, busy held 1 for 300 cycles -> timeout=1 at cycle 256 and FSM=LOAD.
REQ-042 Assert reset=0 during DRAIN beat 30 -> all outputs at reset values next cycle, result[0..29] retained, and no frame_done.
